morse_code_buf: RTL

Parametrised successor to the Morse code register: holds a Morse character (code bits plus length) and serialises it MSB-first, one element per `shft_cnt` strobe, under the control of the downstream element timing FSM. It adds a valid/ready load handshake with a one-entry holding buffer, so the next character is queued while the current one shifts out and follows with no bubble. It also adds explicit inter-word gap generation, length clamping and a character-done pulse. It sits between the character lookup (ROM/keyboard decode) and the Morse timing/output FSM.

---
 rtl/morse_pkg.sv | 14 +
 rtl/morse_char_buf.sv | 47 ++++
 rtl/morse_code_buf.sv | 123 ++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared types and defaults for the Morse character buffer slice.
// Imported by the holding buffer and the top-level shifter.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } morse_st_t;

    localparam int MORSE_GAP_LEN = 7;
    localparam int MORSE_CODE_W  = 8;

endpackage

// File: rtl/morse_char_buf.sv
// One-entry holding buffer that queues the next Morse character
// while the active one is still being serialised.
module morse_char_buf
    import morse_pkg::*;
#(
    parameter int CODE_W = MORSE_CODE_W,
    parameter int LEN_W  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [CODE_W-1:0] wr_code,
    input  logic [LEN_W-1:0]  wr_len,
    output logic [CODE_W-1:0] hold_code,
    output logic [LEN_W-1:0]  hold_len,
    output logic              hold_full,
    output logic              ready
);

    logic [CODE_W-1:0] code_r;
    logic [LEN_W-1:0]  len_r;
    logic              full_r;

    // Capture only into an empty slot so a held item can never be overwritten.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            code_r <= {CODE_W{1'b0}};
            len_r  <= {LEN_W{1'b0}};
            full_r <= 1'b0;
        end else if (push && !full_r) begin
            code_r <= wr_code;
            len_r  <= wr_len;
            full_r <= 1'b1;
        end else if (pop) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    assign hold_code = code_r;
    assign hold_len  = len_r;
    assign hold_full = full_r;
    assign ready     = !full_r;

endmodule

// File: rtl/morse_code_buf.sv
// Morse character register with valid/ready load, one-entry queue and
// MSB-first serialisation driven by the element timing FSM strobe.
module morse_code_buf
    import morse_pkg::*;
#(
    parameter int CODE_W  = MORSE_CODE_W,
    parameter int LEN_W   = 4,
    parameter int GAP_LEN = MORSE_GAP_LEN
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [CODE_W-1:0] charcode_data,
    input  logic [LEN_W-1:0]  charlen_data,
    input  logic              char_valid,
    output logic              char_ready,
    input  logic              shft_cnt,
    output logic              shft_data,
    output logic [LEN_W-1:0]  cntr_data,
    output logic              is_gap,
    output logic              busy,
    output logic              char_done
);

    morse_st_t         state_r, state_s;
    logic [CODE_W-1:0] shift_r, shift_s;
    logic [LEN_W-1:0]  cntr_r, cntr_s;
    logic              done_r, is_gap_r, busy_r;
    logic              accept_s, last_s, direct_s, push_s, pop_s, load_s;
    logic [CODE_W-1:0] ld_code_s, hold_code_s;
    logic [LEN_W-1:0]  ld_len_s, hold_len_s;
    logic              hold_full_s, hold_ready_s;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len > LEN_W'(CODE_W)) begin
            return LEN_W'(CODE_W);
        end else begin
            return len;
        end
    endfunction

    morse_char_buf #(
        .CODE_W (CODE_W),
        .LEN_W  (LEN_W)
    ) u_hold (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push_s),
        .pop       (pop_s),
        .wr_code   (charcode_data),
        .wr_len    (charlen_data),
        .hold_code (hold_code_s),
        .hold_len  (hold_len_s),
        .hold_full (hold_full_s),
        .ready     (hold_ready_s)
    );

    // Route accepts: straight into active when it is (or is about to be) empty, else queue.
    always_comb begin
        accept_s  = char_valid && hold_ready_s;
        last_s    = (state_r != IDLE) && shft_cnt && (cntr_r == LEN_W'(1));
        direct_s  = accept_s && ((state_r == IDLE) || last_s);
        push_s    = accept_s && !direct_s;
        pop_s     = last_s && hold_full_s;
        load_s    = direct_s || pop_s;
        ld_code_s = pop_s ? hold_code_s : charcode_data;
        ld_len_s  = pop_s ? hold_len_s : charlen_data;
    end

    // Next active state, shifter and down-counter.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        cntr_s  = cntr_r;
        if (load_s) begin
            if (ld_len_s == {LEN_W{1'b0}}) begin
                state_s = GAP;
                cntr_s  = LEN_W'(GAP_LEN);
                shift_s = {CODE_W{1'b0}};
            end else begin
                state_s = SHIFT;
                cntr_s  = clamp_len(ld_len_s);
                shift_s = ld_code_s;
            end
        end else if (last_s) begin
            // Clear leftover code bits beyond the length so idle output stays 0.
            state_s = IDLE;
            cntr_s  = {LEN_W{1'b0}};
            shift_s = {CODE_W{1'b0}};
        end else if ((state_r != IDLE) && shft_cnt) begin
            shift_s = {shift_r[CODE_W-2:0], 1'b0};
            cntr_s  = cntr_r - LEN_W'(1);
        end else begin
            state_s = state_r;
        end
    end

    // Active register, status flags and done pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            shift_r  <= {CODE_W{1'b0}};
            cntr_r   <= {LEN_W{1'b0}};
            done_r   <= 1'b0;
            is_gap_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            shift_r  <= shift_s;
            cntr_r   <= cntr_s;
            done_r   <= last_s;
            is_gap_r <= (state_s == GAP);
            busy_r   <= (state_s != IDLE);
        end
    end

    assign shft_data  = shift_r[CODE_W-1];
    assign cntr_data  = cntr_r;
    assign is_gap     = is_gap_r;
    assign busy       = busy_r;
    assign char_done  = done_r;
    assign char_ready = hold_ready_s;

endmodule
